resource_arbiter: RTL
=====================

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesting pipelines (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, shared-resource data width.
REQ-003 SHALL have parameter MAX_HOLD, default 16, grant hold limit in cycles (used only under ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port arbiter_req  input  N_REQ  per-pipeline request, bit i from pipeline i.
REQ-007 SHALL have port arbiter_grant  output  N_REQ  one-hot-or-zero grant, bit i to pipeline i.
REQ-008 SHALL have port resource_input  input  N_REQ*DATA_W  packed pipeline operands, slice i = bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port resource_output  output  DATA_W  registered resource result, broadcast to all pipelines.
REQ-010 SHALL have port res_op  output  DATA_W  operand driven to the shared resource.
REQ-011 SHALL have port res_op_valid  output  1  operand on res_op valid this cycle.
REQ-012 SHALL have port res_result  input  DATA_W  resource result, valid exactly 1 cycle after res_op_valid.
REQ-013 SHALL have port owner  output  log2(N_REQ)  index of current grant holder, 0 when idle.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-015 IDLE -> GRANT on any arbiter_req bit high; winner chosen round-robin starting at rr_ptr; arbiter_grant asserts the cycle after request is sampled (1-cycle latency).
REQ-016 GRANT SHALL hold while arbiter_req[owner] stays high; other requests ignored (no preemption).
REQ-017 GRANT -> RELEASE when arbiter_req[owner] drops; arbiter_grant all-zero in RELEASE; rr_ptr <= owner+1 modulo N_REQ (wraps N_REQ-1 -> 0).
REQ-018 RELEASE -> IDLE unconditionally after 1 cycle; guarantees one dead cycle between owners.
REQ-019 In GRANT, res_op SHALL equal resource_input slice [owner] combinationally and res_op_valid SHALL be 1; otherwise res_op_valid 0 and res_op 0.
REQ-020 resource_output SHALL register res_result one cycle after each res_op_valid cycle and hold its value otherwise.
REQ-021 Simultaneous requests SHALL resolve to lowest index >= rr_ptr, else lowest index overall.
REQ-022 Request dropping in the same cycle grant asserts SHALL still traverse GRANT -> RELEASE (one-cycle grant).
REQ-023 arbiter_grant SHALL never have more than one bit set.

Reset
REQ-024 reset SHALL force IDLE, arbiter_grant 0, owner 0, rr_ptr 0, res_op_valid 0, resource_output 0, hold counter 0, on the next edge, including mid-GRANT.
REQ-025 Requests present during reset SHALL be arbitrated on the first cycle after reset deasserts.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN SHALL compile in a hold counter: in GRANT, counter increments each cycle; at MAX_HOLD cycles FSM forces RELEASE, rr_ptr advances, and that owner is masked from winning until its request drops.
REQ-027 Without ARB_TIMEOUT_EN, no counter exists and grant holds indefinitely per REQ-016.

Structure
REQ-028 Shared package SHALL hold the FSM state enum (IDLE, GRANT, RELEASE) and the default DATA_W constant, shared with pipeline_top.
REQ-029 Round-robin winner selection SHALL be a sub-module rr_select (inputs req, rr_ptr; outputs valid, index).

Verification
REQ-030 Single request: req=0b0001 at cycle 0 -> grant=0b0001 at cycle 1, owner=0, res_op=slice 0; res_result 0xA5 -> resource_output 0xA5 one cycle later.
REQ-031 Fairness: req=0b1111 held, each requester drops after 2 grant cycles -> grant order 0,1,2,3,0 with one all-zero RELEASE cycle between.
REQ-032 Wrap: rr_ptr=3, req=0b1001 -> grant index 3, then after release grant index 0.
REQ-033 Reset mid-GRANT: owner=2, reset pulse 1 cycle -> next cycle grant=0, owner=0, resource_output=0; req still high -> grant=0b0001 if req[0] else lowest set bit.
REQ-034 With ARB_TIMEOUT_EN, MAX_HOLD=4: req[1] held 10 cycles, req[2] high -> grant[1] for 4 cycles, RELEASE, then grant[2]; grant[1] not re-issued while req[1] stays high.
REQ-035 Assertion throughout all tests: arbiter_grant is one-hot-or-zero and res_op_valid equals |arbiter_grant.

Source files
------------

// File: rtl/resource_arbiter_pkg.sv
// Shared types and constants for the resource arbiter and pipeline_top.
package resource_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/resource_arbiter_rr_select.sv
// Round-robin winner pick: lowest requesting index >= rr_ptr, else lowest overall.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
        if (!hi_found && (i >= int'(rr_ptr))) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    valid = lo_found;
    index = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin, non-preemptive arbiter for one shared single-cycle resource.
// Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD grant limit with owner masking.
module resource_arbiter
  import resource_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MAX_HOLD = 16,
  localparam int OWN_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        arbiter_req,
  output logic [N_REQ-1:0]        arbiter_grant,
  input  logic [N_REQ*DATA_W-1:0] resource_input,
  output logic [DATA_W-1:0]       resource_output,
  output logic [DATA_W-1:0]       res_op,
  output logic                    res_op_valid,
  input  logic [DATA_W-1:0]       res_result,
  output logic [OWN_W-1:0]        owner
);

  localparam logic [N_REQ-1:0] GRANT_ONE = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1) begin : g_bad_params
    $error("resource_arbiter: N_REQ must be 2..8 and MAX_HOLD >= 1");
  end

  arb_state_t       state;
  logic [OWN_W-1:0] rr_ptr;
  logic [OWN_W-1:0] next_ptr;
  logic [N_REQ-1:0] req_eff;
  logic             sel_valid;
  logic [OWN_W-1:0] sel_idx;
  logic             release_now;
  logic             vld_p1;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  masked;
  logic              hold_expired;

  // A timed-out owner stays out of arbitration until it lets go of its request.
  assign req_eff      = arbiter_req & ~masked;
  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now  = !arbiter_req[owner] || hold_expired;
`else
  assign req_eff      = arbiter_req;
  assign release_now  = !arbiter_req[owner];
`endif

  assign next_ptr = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + OWN_W'(1);

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (OWN_W)
  ) u_rr_select (
    .req    (req_eff),
    .rr_ptr (rr_ptr),
    .valid  (sel_valid),
    .index  (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      arbiter_grant <= '0;
      owner         <= '0;
      rr_ptr        <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt      <= '0;
      masked        <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      masked <= masked & arbiter_req;
`endif
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
          if (sel_valid) begin
            state         <= GRANT;
            arbiter_grant <= GRANT_ONE << sel_idx;
            owner         <= sel_idx;
          end
        end
        GRANT: begin
          if (release_now) begin
            state         <= RELEASE;
            arbiter_grant <= '0;
            owner         <= '0;
            rr_ptr        <= next_ptr;
`ifdef ARB_TIMEOUT_EN
            hold_cnt      <= '0;
            if (hold_expired) masked[owner] <= arbiter_req[owner];
          end else begin
            hold_cnt      <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          state         <= IDLE;
          arbiter_grant <= '0;
          owner         <= '0;
        end
      endcase
    end
  end

  assign res_op_valid = (state == GRANT);
  assign res_op       = res_op_valid ? resource_input[owner*DATA_W +: DATA_W] : '0;

  // p1: resource returns its result one cycle after the operand was valid
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1          <= 1'b0;
      resource_output <= '0;
    end else begin
      vld_p1 <= res_op_valid;
      if (vld_p1) resource_output <= res_result;
    end
  end

endmodule
